// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   - state_t  : sequencer states (RUN / MEM_WAIT / ERR)
//   - REG_W    : register-number width
//   - ZERO_REG : hard-wired zero register; writes to it never create hazards
package pipe_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERR      = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   i_ex_mem_read : EX-stage instruction is a load
//   i_ex_rd       : EX-stage destination register
//   i_id_rs       : rs of the instruction in ID
//   i_id_rt       : rt of the instruction in ID
//   i_id_uses_rt  : ID instruction reads rt as a source
//   o_lu_hz       : ID must wait one cycle for the load result
module hazard_unit
    import pipe_pkg::*;
(
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rt,
    output logic             o_lu_hz
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (i_ex_rd == i_id_rs);
    // rt only matters when the ID instruction actually sources it (not an I-type dest)
    assign w_rt_match = i_id_uses_rt && (i_ex_rd == i_id_rt);

    assign o_lu_hz = i_ex_mem_read && (i_ex_rd != ZERO_REG) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Resolves load-use hazards (ID), taken branches (MEM) and multi-cycle data
// memory accesses (req/ack with timeout), and counts stalled cycles.
// Ports:
//   clk, rst                       : clock, async active-low reset
//   id_rs, id_rt, id_uses_rt       : ID-stage source operands
//   ex_MemRead, ex_reg_write_no    : EX-stage load and its destination
//   mem_Branch, mem_zero           : MEM-stage branch and its condition
//   mem_MemRead, mem_MemWrite      : MEM-stage data memory access
//   dmem_ack / dmem_req            : data memory handshake
//   pc_wr, *_wr                    : PC / pipeline register write enables
//   *_flush                        : insert a bubble at the register input
//   err                            : sticky memory-timeout error
//   stall_cnt                      : saturating count of cycles with pc_wr=0
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_MemRead,
    input  logic [REG_W-1:0] ex_reg_write_no,
    input  logic             mem_Branch,
    input  logic             mem_zero,
    input  logic             mem_MemRead,
    input  logic             mem_MemWrite,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_wr,
    output logic             if_id_wr,
    output logic             id_ex_wr,
    output logic             ex_mem_wr,
    output logic             mem_wb_wr,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_err;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_mem_op;
    logic w_br_tk;
    logic w_lu_hz;
    logic w_req;
    logic w_freeze;

    hazard_unit u_hazard (
        .i_ex_mem_read (ex_MemRead),
        .i_ex_rd       (ex_reg_write_no),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .i_id_uses_rt  (id_uses_rt),
        .o_lu_hz       (w_lu_hz)
    );

    assign w_mem_op = mem_MemRead || mem_MemWrite;
    assign w_br_tk  = mem_Branch && mem_zero;

    // Request is held for the whole wait; ack is only meaningful while requesting.
    assign w_req    = ((r_state == S_RUN) && w_mem_op) || (r_state == S_MEM_WAIT);
    assign w_freeze = (w_req && !dmem_ack) || (r_state == S_ERR);

    assign dmem_req  = w_req;
    assign err       = r_err;
    assign stall_cnt = r_stall_cnt;

    // Enable/flush decode. Memory freeze dominates; a branch that arrives with a
    // memory op therefore takes effect on the cycle the access completes.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        pc_wr        = 1'b0;
        if_id_wr     = 1'b0;
        id_ex_wr     = 1'b0;
        ex_mem_wr    = 1'b0;
        mem_wb_wr    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (!w_freeze) begin
            ex_mem_wr = 1'b1;
            mem_wb_wr = 1'b1;
            id_ex_wr  = 1'b1;
            if (w_br_tk) begin
                // Squash the three younger instructions on the wrong path.
                pc_wr        = 1'b1;
                if_id_wr     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (w_lu_hz) begin
                // Hold PC and IF_ID, send a bubble into EX.
                id_ex_flush = 1'b1;
            end else begin
                pc_wr    = 1'b1;
                if_id_wr = 1'b1;
            end
        end
    end

    // Memory-access sequencer. r_wait_cnt counts MEM_WAIT cycles seen without ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_mem_op && !dmem_ack) begin
                        r_state    <= S_MEM_WAIT;
                        r_wait_cnt <= WAIT_W'(1);
                    end
                end
                S_MEM_WAIT: begin
                    if (dmem_ack) begin
                        r_state    <= S_RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == WAIT_W'(WAIT_MAX)) begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                S_ERR: begin
                    r_state <= S_ERR;
                    r_err   <= 1'b1;
                end
                default: begin
                    r_state    <= S_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // Stall-cycle performance counter, sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (!pc_wr && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the sequencing rules.
module tb_pipe_ctrl;

    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 4;
    localparam int SAT      = 15;

    // Expected-output vectors: {req, pc, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr, if_id_fl, id_ex_fl, ex_mem_fl}
    localparam logic [8:0] V_NORMAL = 9'b0_1_1111_000;
    localparam logic [8:0] V_LU     = 9'b0_0_0111_010;
    localparam logic [8:0] V_BRANCH = 9'b0_1_1111_111;
    localparam logic [8:0] V_WAIT   = 9'b1_0_0000_000;
    localparam logic [8:0] V_ACK    = 9'b1_1_1111_000;
    localparam logic [8:0] V_DEAD   = 9'b0_0_0000_000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_reg_write_no = '0;
    logic       id_uses_rt = 1'b0, ex_MemRead = 1'b0;
    logic       mem_Branch = 1'b0, mem_zero = 1'b0;
    logic       mem_MemRead = 1'b0, mem_MemWrite = 1'b0, dmem_ack = 1'b0;
    logic       dmem_req, pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, err;
    logic [CNT_W-1:0] stall_cnt;
    logic [8:0] outs;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0=running, 1=waiting on memory, 2=dead after timeout
    int m_mode = 0;
    int m_waited = 0;
    bit m_err = 0;
    int m_stall = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_MemRead(ex_MemRead), .ex_reg_write_no(ex_reg_write_no),
        .mem_Branch(mem_Branch), .mem_zero(mem_zero),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .dmem_ack(dmem_ack), .dmem_req(dmem_req), .pc_wr(pc_wr),
        .if_id_wr(if_id_wr), .id_ex_wr(id_ex_wr), .ex_mem_wr(ex_mem_wr), .mem_wb_wr(mem_wb_wr),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .err(err), .stall_cnt(stall_cnt)
    );

    assign outs = {dmem_req, pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
                   if_id_flush, id_ex_flush, ex_mem_flush};

    // What the pipeline should do this cycle, from the stall/flush rules.
    function automatic logic [8:0] model_outs();
        bit mem_op, branch_taken, load_use, requesting, waiting;
        mem_op       = mem_MemRead || mem_MemWrite;
        branch_taken = mem_Branch && mem_zero;
        load_use     = ex_MemRead && (ex_reg_write_no != 0) &&
                       (ex_reg_write_no == id_rs || (id_uses_rt && ex_reg_write_no == id_rt));
        requesting   = (m_mode == 0 && mem_op) || m_mode == 1;
        waiting      = (m_mode == 2) || (requesting && !dmem_ack);
        if (waiting)           return {requesting, 8'b0};
        else if (branch_taken) return {requesting, V_BRANCH[7:0]};
        else if (load_use)     return {requesting, V_LU[7:0]};
        else                   return {requesting, V_NORMAL[7:0]};
    endfunction

    // One clock edge; the model advances with the same inputs the DUT saw.
    task automatic tick();
        logic [8:0] e;
        bit mem_op;
        e = model_outs();
        mem_op = mem_MemRead || mem_MemWrite;
        @(posedge clk);
        if (!e[7] && m_stall < SAT) m_stall++;
        if (m_mode == 0) begin
            if (mem_op && !dmem_ack) begin m_mode = 1; m_waited = 1; end
        end else if (m_mode == 1) begin
            if (dmem_ack) m_mode = 0;
            else if (m_waited == WAIT_MAX) begin m_mode = 2; m_err = 1; end
            else m_waited++;
        end
        #1;
    endtask

    task automatic set_idle();
        id_rs = '0; id_rt = '0; id_uses_rt = 0; ex_MemRead = 0; ex_reg_write_no = '0;
        mem_Branch = 0; mem_zero = 0; mem_MemRead = 0; mem_MemWrite = 0; dmem_ack = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        m_mode = 0; m_waited = 0; m_err = 0; m_stall = 0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        mem_MemRead = 1;
        #2;
        checks++;
        if (outs !== V_WAIT) begin errors++; $display("FAIL reset_req outs=%b exp=%b", outs, V_WAIT); end
        checks++;
        if (err !== 1'b0 || stall_cnt !== '0) begin
            errors++; $display("FAIL reset_regs err=%b stall=%0d exp 0/0", err, stall_cnt);
        end
        mem_MemRead = 0;
        #1;
        checks++;
        if (outs !== V_NORMAL) begin errors++; $display("FAIL reset_idle outs=%b exp=%b", outs, V_NORMAL); end
        apply_reset();
    endtask

    task automatic test_load_use();
        apply_reset(); set_idle();
        ex_MemRead = 1; ex_reg_write_no = 5'd8; id_rs = 5'd8; id_rt = 5'd3;
        @(negedge clk); checks++;
        if (outs !== V_LU) begin errors++; $display("FAIL lu_rs outs=%b exp=%b", outs, V_LU); end
        tick();
        ex_MemRead = 0;  // bubble now sits in EX
        @(negedge clk); checks++;
        if (outs !== V_NORMAL || stall_cnt !== 4'd1) begin
            errors++; $display("FAIL lu_release outs=%b stall=%0d exp=%b/1", outs, stall_cnt, V_NORMAL);
        end
        tick();
        ex_MemRead = 1; ex_reg_write_no = 5'd5; id_rs = 5'd1; id_rt = 5'd5; id_uses_rt = 1;
        @(negedge clk); checks++;
        if (outs !== V_LU) begin errors++; $display("FAIL lu_rt outs=%b exp=%b", outs, V_LU); end
        id_uses_rt = 0;
        @(posedge clk); #1;
        @(negedge clk); checks++;
        if (outs !== V_NORMAL) begin errors++; $display("FAIL lu_rt_unused outs=%b exp=%b", outs, V_NORMAL); end
        set_idle();
    endtask

    task automatic test_zero_dest();
        apply_reset(); set_idle();
        ex_MemRead = 1; ex_reg_write_no = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1;
        @(negedge clk); checks++;
        if (outs !== V_NORMAL) begin errors++; $display("FAIL zero_dest outs=%b exp=%b", outs, V_NORMAL); end
        tick();
        @(negedge clk); checks++;
        if (stall_cnt !== 4'd0) begin errors++; $display("FAIL zero_dest_cnt stall=%0d exp 0", stall_cnt); end
        set_idle();
    endtask

    task automatic test_branch();
        apply_reset(); set_idle();
        ex_MemRead = 1; ex_reg_write_no = 5'd9; id_rs = 5'd9; mem_Branch = 1; mem_zero = 1;
        @(negedge clk); checks++;
        if (outs !== V_BRANCH) begin errors++; $display("FAIL br_over_lu outs=%b exp=%b", outs, V_BRANCH); end
        tick();
        mem_zero = 0;  // not-taken branch leaves the load-use stall in force
        @(negedge clk); checks++;
        if (outs !== V_LU || stall_cnt !== 4'd0) begin
            errors++; $display("FAIL br_not_taken outs=%b stall=%0d exp=%b/0", outs, stall_cnt, V_LU);
        end
        set_idle();
        tick();
    endtask

    task automatic test_mem_latency();
        apply_reset(); set_idle();
        mem_MemRead = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); checks++;
            if (outs !== V_WAIT) begin errors++; $display("FAIL mem_wait%0d outs=%b exp=%b", c, outs, V_WAIT); end
            tick();
        end
        dmem_ack = 1;
        @(negedge clk); checks++;
        if (outs !== V_ACK) begin errors++; $display("FAIL mem_ack outs=%b exp=%b", outs, V_ACK); end
        tick();
        set_idle();
        @(negedge clk); checks++;
        if (outs !== V_NORMAL || stall_cnt !== 4'd2) begin
            errors++; $display("FAIL mem_done outs=%b stall=%0d exp=%b/2", outs, stall_cnt, V_NORMAL);
        end
        tick();
    endtask

    task automatic test_timeout();
        apply_reset(); set_idle();
        mem_MemWrite = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); checks++;
            if (outs !== V_WAIT || err !== 1'b0) begin
                errors++; $display("FAIL to_wait%0d outs=%b err=%b exp=%b/0", c, outs, err, V_WAIT);
            end
            tick();
        end
        for (int c = 0; c < 14; c++) begin
            dmem_ack = c[0];
            mem_MemRead = c[1];
            @(negedge clk); checks++;
            if (outs !== V_DEAD || err !== 1'b1) begin
                errors++; $display("FAIL to_err%0d outs=%b err=%b exp=%b/1", c, outs, err, V_DEAD);
            end
            tick();
        end
        @(negedge clk); checks++;
        if (stall_cnt !== 4'd15) begin errors++; $display("FAIL stall_sat stall=%0d exp 15", stall_cnt); end
        set_idle();
    endtask

    task automatic test_reset_mid_wait();
        apply_reset(); set_idle();
        mem_MemRead = 1;
        tick(); tick();
        @(negedge clk);
        rst = 1'b0;
        mem_MemRead = 0;
        #1; checks++;
        if (outs !== V_NORMAL || err !== 1'b0 || stall_cnt !== '0) begin
            errors++; $display("FAIL rst_mid_wait outs=%b err=%b stall=%0d exp=%b/0/0", outs, err, stall_cnt, V_NORMAL);
        end
        m_mode = 0; m_waited = 0; m_err = 0; m_stall = 0;
        @(posedge clk); #1 rst = 1'b1;
        mem_MemRead = 1;
        @(negedge clk); checks++;
        if (outs !== V_WAIT) begin errors++; $display("FAIL rst_then_req outs=%b exp=%b", outs, V_WAIT); end
        set_idle();
        tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_MemRead      = 1'($urandom_range(0, 1));
            ex_reg_write_no = 5'($urandom_range(0, 3));
            mem_MemRead     = ($urandom_range(0, 5) == 0);
            mem_MemWrite    = ($urandom_range(0, 7) == 0);
            mem_Branch      = ($urandom_range(0, 3) == 0);
            mem_zero        = 1'($urandom_range(0, 1));
            dmem_ack        = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            checks++;
            if (outs !== model_outs() || err !== m_err || stall_cnt !== CNT_W'(m_stall)) begin
                errors++;
                $display("FAIL rand%0d outs=%b err=%b stall=%0d exp=%b/%0d/%0d",
                         c, outs, err, stall_cnt, model_outs(), m_err, m_stall);
            end
            tick();
            if ((m_err && $urandom_range(0, 3) == 0) || (c % 97 == 96)) apply_reset();
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_dest();
        test_branch();
        test_mem_latency();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
